// File: rtl/div_seq.sv
// div_seq: 33-cycle signed 32-bit restoring divider (MIPS semantics); DIV_ZERO_TRAP_EN enables divide-by-zero trap
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic        div_zero
`endif
);
  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;
  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem, r_quo, r_d, r_hi, r_lo;
  logic        r_sa, r_sb, r_busy, r_done;
  logic [31:0] w_abs_a, w_abs_b, w_sub, w_rem_nx, w_quo_nx;
  logic [32:0] w_rem_sh;
  logic        w_ge, w_trap;
`ifdef DIV_ZERO_TRAP_EN
  logic        r_div_zero;
  assign div_zero = r_div_zero;
`endif
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = r_busy;
  assign done = r_done;
  // operand magnitudes and one restoring shift-subtract step
  always_comb begin
    w_abs_a  = a[31] ? -a : a;
    w_abs_b  = b[31] ? -b : b;
    w_rem_sh = {r_rem, r_quo[31]};
    w_ge     = w_rem_sh >= {1'b0, r_d};
    w_sub    = w_rem_sh[31:0] - r_d;
    w_rem_nx = w_ge ? w_sub : w_rem_sh[31:0];
    w_quo_nx = {r_quo[30:0], w_ge};
`ifdef DIV_ZERO_TRAP_EN
    w_trap   = (b == 32'd0);
`else
    w_trap   = 1'b0;
`endif
  end
  // control FSM: capture operands, iterate 32 steps, apply signs and publish result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 5'd0;
      r_rem   <= 32'd0;
      r_quo   <= 32'd0;
      r_d     <= 32'd0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      r_div_zero <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      r_div_zero <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (start && w_trap) begin
            r_done <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
            r_div_zero <= 1'b1;
`endif
          end else if (start) begin
            r_rem   <= 32'd0;
            r_quo   <= w_abs_a;
            r_d     <= w_abs_b;
            r_sa    <= a[31];
            r_sb    <= b[31];
            r_cnt   <= 5'd31;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd0) r_state <= SIGN;
        end
        SIGN: begin
          r_lo    <= (r_sa ^ r_sb) ? -r_quo : r_quo;
          r_hi    <= r_sa ? -r_rem : r_rem;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
